// File: rtl/timer_seq_pkg.sv
// Shared types and defaults for the timer sequencer.
// Optional abort input: TIMER_SEQ_ABORT_EN.
package timer_seq_pkg;

  typedef enum logic [1:0] {
    SEARCH,
    SHIFT,
    COUNT,
    DONE
  } state_t;

  localparam logic [3:0] PATTERN_DEF    = 4'b1101;
  localparam int         DELAY_BITS_DEF = 4;
  localparam int         TICKS_DEF      = 1000;

  function automatic logic is_active(input state_t s);
    return s != SEARCH;
  endfunction

endpackage

// File: rtl/timer_sequencer_pattern_detect.sv
// Serial start-pattern detector: 4-bit window = 3 stored bits + live bit.
// Overlapping matches are found because the history keeps shifting.
module pattern_detect
  import timer_seq_pkg::*;
#(
  parameter logic [3:0] PATTERN = PATTERN_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  input  logic i_clr,
  input  logic i_data,
  output logic o_match
);

  logic [2:0] r_hist;
  logic [3:0] w_window;

  assign w_window = {r_hist, i_data};
  assign o_match  = i_en && (w_window == PATTERN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hist <= '0;
    end else if (i_clr) begin
      r_hist <= '0;
    end else if (i_en) begin
      r_hist <= w_window[2:0];
    end
  end

endmodule

// File: rtl/timer_sequencer.sv
// Sequencer for the shift/down-count timer datapath.
// Define TIMER_SEQ_ABORT_EN to add the abort input.
module timer_sequencer
  import timer_seq_pkg::*;
#(
  parameter logic [3:0] PATTERN        = PATTERN_DEF,
  parameter int         DELAY_BITS     = DELAY_BITS_DEF,
  parameter int         TICKS_PER_UNIT = TICKS_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  data,
  input  logic                  ack,
`ifdef TIMER_SEQ_ABORT_EN
  input  logic                  abort,
`endif
  input  logic [DELAY_BITS-1:0] q_in,
  output logic                  shift_ena,
  output logic                  count_ena,
  output logic                  counting,
  output logic                  done
);

  localparam int PW = $clog2(TICKS_PER_UNIT);
  localparam int BW = $clog2(DELAY_BITS + 1);

  localparam logic [PW-1:0] P_LAST = PW'(TICKS_PER_UNIT - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DELAY_BITS - 1);

  state_t r_state;
  state_t w_next;

  logic [PW-1:0] r_presc;
  logic [BW-1:0] r_bits;

  logic w_abort;
  logic w_match;
  logic w_term;
  logic w_zero;

`ifdef TIMER_SEQ_ABORT_EN
  assign w_abort = abort && is_active(r_state);
`else
  assign w_abort = 1'b0;
`endif

  assign w_term = (r_presc == P_LAST);
  assign w_zero = (q_in == '0);

  pattern_detect #(
    .PATTERN (PATTERN)
  ) u_detect (
    .clk     (clk),
    .reset   (reset),
    .i_en    (r_state == SEARCH),
    .i_clr   (r_state != SEARCH),
    .i_data  (data),
    .o_match (w_match)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      SEARCH: if (w_match) w_next = SHIFT;
      SHIFT:  if (r_bits == B_LAST) w_next = COUNT;
      COUNT:  if (w_term && w_zero) w_next = DONE;
      DONE:   if (ack) w_next = SEARCH;
      default: w_next = SEARCH;
    endcase
    if (w_abort) w_next = SEARCH;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= SEARCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Both counters restart from zero on every entry into their state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bits <= '0;
    end else if (r_state != SHIFT || w_next != SHIFT) begin
      r_bits <= '0;
    end else begin
      r_bits <= r_bits + BW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc <= '0;
    end else if (r_state != COUNT || w_next != COUNT) begin
      r_presc <= '0;
    end else if (w_term) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  assign shift_ena = (r_state == SHIFT);
  assign counting  = (r_state == COUNT);
  assign done      = (r_state == DONE);
  assign count_ena = counting && w_term && !w_zero && !w_abort;

endmodule
